// File: rtl/fused_pkg.sv
// Format tables, lane layout helpers and shared types for the fused alignment prep stage.
// Config encodings come from define.sv when present; otherwise local defaults are used.
`ifndef CONFIG_WIDTH
`define CONFIG_WIDTH 3
`endif
`ifndef CONFIG_FP32
`define CONFIG_FP32 3'd0
`endif
`ifndef CONFIG_FP16
`define CONFIG_FP16 3'd1
`endif
`ifndef CONFIG_BF16
`define CONFIG_BF16 3'd2
`endif
`ifndef CONFIG_FP8_E4M3
`define CONFIG_FP8_E4M3 3'd3
`endif
`ifndef CONFIG_FP8_E5M2
`define CONFIG_FP8_E5M2 3'd4
`endif

package fused_pkg;

  localparam int CFG_W     = `CONFIG_WIDTH;
  localparam int NUM_LANES = 4;
  localparam int MAN_W     = 24;
  localparam int DIFF_W    = 20;

  localparam logic [CFG_W-1:0] CFG_FP32 = CFG_W'(`CONFIG_FP32);
  localparam logic [CFG_W-1:0] CFG_FP16 = CFG_W'(`CONFIG_FP16);
  localparam logic [CFG_W-1:0] CFG_BF16 = CFG_W'(`CONFIG_BF16);
  localparam logic [CFG_W-1:0] CFG_E4M3 = CFG_W'(`CONFIG_FP8_E4M3);
  localparam logic [CFG_W-1:0] CFG_E5M2 = CFG_W'(`CONFIG_FP8_E5M2);

  typedef enum logic [2:0] {
    FMT_FP32,
    FMT_FP16,
    FMT_BF16,
    FMT_E4M3,
    FMT_E5M2
  } fmt_e;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_e;

  typedef struct packed {
    logic             sign;
    logic [7:0]       exp;
    logic [MAN_W-1:0] man;
  } elem_t;

  function automatic int fmt_exp_w(input fmt_e f);
    case (f)
      FMT_FP16: return 5;
      FMT_E4M3: return 4;
      FMT_E5M2: return 5;
      default:  return 8;
    endcase
  endfunction

  function automatic int fmt_man_w(input fmt_e f);
    case (f)
      FMT_FP16: return 10;
      FMT_BF16: return 7;
      FMT_E4M3: return 3;
      FMT_E5M2: return 2;
      default:  return 23;
    endcase
  endfunction

  function automatic int fmt_lanes(input fmt_e f);
    case (f)
      FMT_FP16, FMT_BF16: return 2;
      FMT_E4M3, FMT_E5M2: return 4;
      default:            return 1;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_mask(input fmt_e f);
    case (f)
      FMT_FP16, FMT_BF16: return 4'b0101;
      FMT_E4M3, FMT_E5M2: return 4'b1111;
      default:            return 4'b0001;
    endcase
  endfunction

  function automatic int man_base(input fmt_e f, input int lane);
    case (f)
      FMT_FP16, FMT_BF16: return (lane == 2) ? 12 : 0;
      FMT_E4M3, FMT_E5M2: return 6 * lane;
      default:            return 0;
    endcase
  endfunction

  function automatic int diff_base(input fmt_e f, input int lane);
    case (f)
      FMT_FP16, FMT_BF16: return (lane == 2) ? 10 : 0;
      FMT_E4M3, FMT_E5M2: return 5 * lane;
      default:            return 0;
    endcase
  endfunction

  // Unknown encodings collapse to FP32 so the stage never stalls on a bad config.
  function automatic fmt_e cfg_to_fmt(input logic [CFG_W-1:0] cfg);
    case (cfg)
      CFG_FP16: return FMT_FP16;
      CFG_BF16: return FMT_BF16;
      CFG_E4M3: return FMT_E4M3;
      CFG_E5M2: return FMT_E5M2;
      default:  return FMT_FP32;
    endcase
  endfunction

  function automatic logic [CFG_W-1:0] fmt_to_cfg(input fmt_e f);
    case (f)
      FMT_FP16: return CFG_FP16;
      FMT_BF16: return CFG_BF16;
      FMT_E4M3: return CFG_E4M3;
      FMT_E5M2: return CFG_E5M2;
      default:  return CFG_FP32;
    endcase
  endfunction

  function automatic logic [31:0] get_bits(input logic [31:0] word, input int lsb, input int width);
    return (word >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

  // Subnormals read as exponent 1 with a clear hidden bit.
  function automatic elem_t unpack_elem(input logic [31:0] word, input fmt_e f, input int lane);
    elem_t       e;
    logic [31:0] frac;
    logic [7:0]  exp_raw;
    int          ew;
    int          mw;
    ew      = fmt_exp_w(f);
    mw      = fmt_man_w(f);
    frac    = get_bits(word, 8 * lane, mw);
    exp_raw = 8'(get_bits(word, 8 * lane + mw, ew));
    e.sign  = |get_bits(word, 8 * lane + mw + ew, 1);
    e.exp   = (exp_raw == 8'd0) ? 8'd1 : exp_raw;
    e.man   = MAN_W'(frac) | ((exp_raw != 8'd0) ? (24'd1 << mw) : 24'd0);
    return e;
  endfunction

  // E4M3 has no infinity; only S.1111.111 is treated as special there.
  function automatic logic is_special(input logic [31:0] word, input fmt_e f, input int lane);
    logic [31:0] frac;
    logic [31:0] exp_raw;
    int          ew;
    int          mw;
    ew      = fmt_exp_w(f);
    mw      = fmt_man_w(f);
    frac    = get_bits(word, 8 * lane, mw);
    exp_raw = get_bits(word, 8 * lane + mw, ew);
    if (exp_raw != ((32'd1 << ew) - 32'd1)) return 1'b0;
    if (f == FMT_E4M3) return (frac == 32'd7);
    return 1'b1;
  endfunction

endpackage

// File: rtl/fused_skid_buf.sv
// Two-entry valid/ready skid buffer with registered ready/valid and synchronous reset.
// state      | meaning
// SKID_EMPTY | no beat held, o_valid low
// SKID_ONE   | head beat in r_mem[0], one slot free
// SKID_FULL  | head in r_mem[0], next in r_mem[1], o_ready low
module fused_skid_buf
  import fused_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  skid_state_e      r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ready;
  logic             r_valid;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = r_valid & i_ready;
  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_mem[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SKID_EMPTY;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          r_ready <= 1'b1;
          if (w_push) begin
            r_mem[0] <= i_data;
            r_valid  <= 1'b1;
            r_state  <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_push && !w_pop) begin
            r_mem[1] <= i_data;
            r_ready  <= 1'b0;
            r_state  <= SKID_FULL;
          end else if (w_push && w_pop) begin
            r_mem[0] <= i_data;
          end else if (w_pop) begin
            r_valid <= 1'b0;
            r_state <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (w_pop) begin
            r_mem[0] <= r_mem[1];
            r_ready  <= 1'b1;
            r_state  <= SKID_ONE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_valid <= 1'b0;
          r_state <= SKID_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/fused_exp_align_prep.sv
// Operand prep ahead of the fused alignment shifter: unpack lanes, order by magnitude, pack diffs.
// FUSED_ALIGN_SPECIAL_EN adds NaN/Inf lane flagging that zeroes that lane's diff and small mantissa.
module fused_exp_align_prep
  import fused_pkg::*;
#(
  parameter int CONFIG_W = CFG_W,
  parameter int DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [CONFIG_W-1:0]  in_config,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CONFIG_W-1:0]  out_config,
  output logic [MAN_W-1:0]     out_man_small,
  output logic [MAN_W-1:0]     out_man_big,
  output logic [DIFF_W-1:0]    out_diff,
  output logic [DIFF_W-1:0]    out_exp_max,
  output logic [NUM_LANES-1:0] out_swap,
  output logic [NUM_LANES-1:0] out_sign_big,
  output logic [NUM_LANES-1:0] out_eff_sub,
  output logic [NUM_LANES-1:0] out_special
);

  localparam int PAY_W = CONFIG_W + 2 * MAN_W + 2 * DIFF_W + 4 * NUM_LANES;

  fmt_e                 w_fmt;
  logic [NUM_LANES-1:0] w_lane_mask;
  logic [CONFIG_W-1:0]  w_cfg;
  logic [MAN_W-1:0]     w_man_small_l [NUM_LANES];
  logic [MAN_W-1:0]     w_man_big_l   [NUM_LANES];
  logic [DIFF_W-1:0]    w_diff_l      [NUM_LANES];
  logic [DIFF_W-1:0]    w_exp_max_l   [NUM_LANES];
  logic [MAN_W-1:0]     w_man_small;
  logic [MAN_W-1:0]     w_man_big;
  logic [DIFF_W-1:0]    w_diff;
  logic [DIFF_W-1:0]    w_exp_max;
  logic [NUM_LANES-1:0] w_swap_v;
  logic [NUM_LANES-1:0] w_sign_big_v;
  logic [NUM_LANES-1:0] w_eff_sub_v;
  logic [NUM_LANES-1:0] w_special_v;
  logic [PAY_W-1:0]     w_pay_in;
  logic [PAY_W-1:0]     w_pay_out;

  assign w_fmt       = cfg_to_fmt(CFG_W'(in_config));
  assign w_lane_mask = lane_mask(w_fmt);
  assign w_cfg       = CONFIG_W'(fmt_to_cfg(w_fmt));

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    elem_t       w_a;
    elem_t       w_b;
    logic        w_act;
    logic        w_swap;
    logic        w_spec;
    logic [7:0]  w_exp_big;
    logic [7:0]  w_exp_small;
    logic [23:0] w_m_big;
    logic [23:0] w_m_small;

    assign w_a   = unpack_elem(in_a, w_fmt, k);
    assign w_b   = unpack_elem(in_b, w_fmt, k);
    assign w_act = w_lane_mask[k];

    // B wins only when strictly larger, so a full tie keeps A as big.
    assign w_swap = w_act && ((w_b.exp > w_a.exp) ||
                              ((w_b.exp == w_a.exp) && (w_b.man > w_a.man)));

    assign w_exp_big   = w_swap ? w_b.exp : w_a.exp;
    assign w_exp_small = w_swap ? w_a.exp : w_b.exp;
    assign w_m_big     = w_swap ? w_b.man : w_a.man;
    assign w_m_small   = w_swap ? w_a.man : w_b.man;

`ifdef FUSED_ALIGN_SPECIAL_EN
    assign w_spec = w_act && (is_special(in_a, w_fmt, k) || is_special(in_b, w_fmt, k));
`else
    assign w_spec = 1'b0;
`endif

    assign w_swap_v[k]     = w_swap;
    assign w_special_v[k]  = w_spec;
    assign w_sign_big_v[k] = w_act & (w_swap ? w_b.sign : w_a.sign);
    assign w_eff_sub_v[k]  = w_act & (w_a.sign ^ w_b.sign);

    assign w_man_big_l[k]   = w_act ? (w_m_big << man_base(w_fmt, k)) : '0;
    assign w_man_small_l[k] = (w_act && !w_spec) ? (w_m_small << man_base(w_fmt, k)) : '0;
    assign w_diff_l[k]      = (w_act && !w_spec) ?
                              (DIFF_W'(w_exp_big - w_exp_small) << diff_base(w_fmt, k)) : '0;
    assign w_exp_max_l[k]   = w_act ? (DIFF_W'(w_exp_big) << diff_base(w_fmt, k)) : '0;
  end

  // Lane fields never overlap, so OR-merging builds the packed words.
  always_comb begin
    w_man_small = '0;
    w_man_big   = '0;
    w_diff      = '0;
    w_exp_max   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_man_small = w_man_small | w_man_small_l[k];
      w_man_big   = w_man_big   | w_man_big_l[k];
      w_diff      = w_diff      | w_diff_l[k];
      w_exp_max   = w_exp_max   | w_exp_max_l[k];
    end
  end

  assign w_pay_in = {w_cfg, w_man_small, w_man_big, w_diff, w_exp_max,
                     w_swap_v, w_sign_big_v, w_eff_sub_v, w_special_v};

  fused_skid_buf #(
    .WIDTH (PAY_W),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_pay_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_pay_out)
  );

  assign {out_config, out_man_small, out_man_big, out_diff, out_exp_max,
          out_swap, out_sign_big, out_eff_sub, out_special} = w_pay_out;

endmodule

// File: tb/tb_fused_exp_align_prep.sv
// Self-checking bench for fused_exp_align_prep: directed vectors, backpressure, reset, random stream.
// Honors FUSED_ALIGN_SPECIAL_EN in its reference model.
module tb_fused_exp_align_prep;
  import fused_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [CFG_W-1:0] in_config = CFG_FP32;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CFG_W-1:0] out_config;
  logic [23:0]      out_man_small;
  logic [23:0]      out_man_big;
  logic [19:0]      out_diff;
  logic [19:0]      out_exp_max;
  logic [3:0]       out_swap;
  logic [3:0]       out_sign_big;
  logic [3:0]       out_eff_sub;
  logic [3:0]       out_special;

  always #5 clk = ~clk;

  fused_exp_align_prep dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_config     (in_config),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_config    (out_config),
    .out_man_small (out_man_small),
    .out_man_big   (out_man_big),
    .out_diff      (out_diff),
    .out_exp_max   (out_exp_max),
    .out_swap      (out_swap),
    .out_sign_big  (out_sign_big),
    .out_eff_sub   (out_eff_sub),
    .out_special   (out_special)
  );

  typedef struct packed {
    logic [CFG_W-1:0] cfg;
    logic [23:0]      man_small;
    logic [23:0]      man_big;
    logic [19:0]      diff;
    logic [19:0]      exp_max;
    logic [3:0]       swap;
    logic [3:0]       sign_big;
    logic [3:0]       eff_sub;
    logic [3:0]       special;
  } beat_t;

  localparam int EXP_BITS [5] = '{8, 5, 8, 4, 5};
  localparam int MAN_BITS [5] = '{23, 10, 7, 3, 2};

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_pops   = 0;
  beat_t scb [$];
  beat_t held;
  bit    held_v = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CFG_W-1:0] code_of(input int f);
    case (f)
      1:       return CFG_FP16;
      2:       return CFG_BF16;
      3:       return CFG_E4M3;
      4:       return CFG_E5M2;
      default: return CFG_FP32;
    endcase
  endfunction

  // Reference: per-lane arithmetic straight from the format definitions.
  function automatic beat_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [CFG_W-1:0] cfg);
    beat_t r;
    int f, ew, mw, w, mbase, dbase;
    longint unsigned ua, ub, fa, fb, xa, xb, ea, eb, ma, mb, sa, sg_b;
    longint unsigned ebig, esml, mbig, msml, acc_ms, acc_mb, acc_d, acc_x;
    bit a_big, spec;
    f = 0;
    for (int i = 1; i < 5; i++) if (cfg == code_of(i)) f = i;
    ew = EXP_BITS[f];
    mw = MAN_BITS[f];
    w  = 1 + ew + mw;
    r = '0;
    r.cfg = code_of(f);
    acc_ms = 0; acc_mb = 0; acc_d = 0; acc_x = 0;
    for (int k = 0; k < 4; k++) begin
      if (f == 0 && k != 0) continue;
      if ((f == 1 || f == 2) && (k % 2) != 0) continue;
      ua = (64'(a) >> (8 * k)) % (64'd1 << w);
      ub = (64'(b) >> (8 * k)) % (64'd1 << w);
      fa = ua % (64'd1 << mw);
      fb = ub % (64'd1 << mw);
      xa = (ua >> mw) % (64'd1 << ew);
      xb = (ub >> mw) % (64'd1 << ew);
      sa   = ua >> (w - 1);
      sg_b = ub >> (w - 1);
      ea = (xa == 0) ? 1 : xa;
      eb = (xb == 0) ? 1 : xb;
      ma = (xa == 0) ? fa : fa + (64'd1 << mw);
      mb = (xb == 0) ? fb : fb + (64'd1 << mw);
      a_big = (ea > eb) || (ea == eb && ma >= mb);
      ebig = a_big ? ea : eb;
      esml = a_big ? eb : ea;
      mbig = a_big ? ma : mb;
      msml = a_big ? mb : ma;
      spec = 1'b0;
`ifdef FUSED_ALIGN_SPECIAL_EN
      spec = (xa == (64'd1 << ew) - 1 && (f != 3 || fa == 7)) ||
             (xb == (64'd1 << ew) - 1 && (f != 3 || fb == 7));
`endif
      mbase = (f == 0) ? 0 : (f <= 2) ? ((k == 0) ? 0 : 12) : 6 * k;
      dbase = (f == 0) ? 0 : (f <= 2) ? ((k == 0) ? 0 : 10) : 5 * k;
      acc_mb += mbig << mbase;
      acc_x  += ebig << dbase;
      if (!spec) begin
        acc_ms += msml << mbase;
        acc_d  += (ebig - esml) << dbase;
      end
      r.swap[k]     = !a_big;
      r.sign_big[k] = a_big ? sa[0] : sg_b[0];
      r.eff_sub[k]  = sa[0] ^ sg_b[0];
      r.special[k]  = spec;
    end
    r.man_small = acc_ms[23:0];
    r.man_big   = acc_mb[23:0];
    r.diff      = acc_d[19:0];
    r.exp_max   = acc_x[19:0];
    return r;
  endfunction

  function automatic beat_t get_out();
    return {out_config, out_man_small, out_man_big, out_diff, out_exp_max,
            out_swap, out_sign_big, out_eff_sub, out_special};
  endfunction

  task automatic compare_beat(input beat_t e);
    check_eq("config",    out_config,    e.cfg);
    check_eq("man_small", out_man_small, e.man_small);
    check_eq("man_big",   out_man_big,   e.man_big);
    check_eq("diff",      out_diff,      e.diff);
    check_eq("exp_max",   out_exp_max,   e.exp_max);
    check_eq("swap",      out_swap,      e.swap);
    check_eq("sign_big",  out_sign_big,  e.sign_big);
    check_eq("eff_sub",   out_eff_sub,   e.eff_sub);
    check_eq("special",   out_special,   e.special);
  endtask

  // One clock of streaming: score the handshakes seen before the edge, then advance.
  task automatic step();
    if (out_valid && out_ready) begin
      n_pops++;
      if (scb.size() == 0) check_eq("unexpected_beat", out_valid, 1'b0);
      else compare_beat(scb.pop_front());
    end
    if (in_valid && in_ready) scb.push_back(model(in_a, in_b, in_config));
    held_v = out_valid && !out_ready;
    held   = get_out();
    @(posedge clk); #1;
    if (held_v) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_data",  get_out(), held);
    end
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [CFG_W-1:0] cfg);
    in_a = a; in_b = b; in_config = cfg;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("lat_valid", out_valid, 1'b1);
    compare_beat(model(a, b, cfg));
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("pop_empty", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] va [4];
    logic [31:0] vb [4];
    int          sent;
    int          pops0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  in_ready,      1'b0);
    check_eq("rst_out_valid", out_valid,     1'b0);
    check_eq("rst_diff",      out_diff,      20'h0);
    check_eq("rst_man_big",   out_man_big,   24'h0);
    check_eq("rst_man_small", out_man_small, 24'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    send_one(32'h4040_0000, 32'h3F80_0000, CFG_FP32);
    check_eq("fp32_diff",  out_diff,      20'h00001);
    check_eq("fp32_emax",  out_exp_max,   20'h00080);
    check_eq("fp32_big",   out_man_big,   24'hC00000);
    check_eq("fp32_small", out_man_small, 24'h800000);
    check_eq("fp32_swap",  out_swap,      4'b0000);
    check_eq("fp32_sub",   out_eff_sub,   4'b0000);
    pop_one();

    send_one(32'h3C00_4000, 32'h4400_3C00, CFG_FP16);
    check_eq("fp16_diff", out_diff, 20'h00801);
    check_eq("fp16_swap", out_swap, 4'b0100);
    pop_one();

    send_one(32'h0000_0001, 32'h0080_0000, CFG_FP32);
    check_eq("sub_diff",  out_diff,      20'h0);
    check_eq("sub_swap",  out_swap,      4'b0001);
    check_eq("sub_big",   out_man_big,   24'h800000);
    check_eq("sub_small", out_man_small, 24'h000001);
    pop_one();

    send_one(32'h3838_3838, 32'h4040_4040, CFG_E4M3);
    check_eq("e4m3_diff", out_diff,    20'h08421);
    check_eq("e4m3_swap", out_swap,    4'b1111);
    check_eq("e4m3_sub",  out_eff_sub, 4'b0000);
    pop_one();

    send_one(32'h4040_0000, 32'h3F80_0000, CFG_W'(7));
    check_eq("undef_cfg",  out_config, CFG_FP32);
    check_eq("undef_diff", out_diff,   20'h00001);
    pop_one();

    send_one(32'h7F80_0000, 32'h3F80_0000, CFG_FP32);
`ifdef FUSED_ALIGN_SPECIAL_EN
    check_eq("spec_flag",  out_special,   4'b0001);
    check_eq("spec_diff",  out_diff,      20'h0);
    check_eq("spec_small", out_man_small, 24'h0);
`else
    check_eq("spec_flag",  out_special,   4'b0000);
`endif
    pop_one();

    // Backpressure: four beats offered against a stalled sink.
    for (int i = 0; i < 4; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    out_ready = 1'b0;
    in_config = CFG_BF16;
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (sent < 4);
      in_a = va[(sent < 4) ? sent : 3];
      in_b = vb[(sent < 4) ? sent : 3];
      if (in_valid && in_ready) sent++;
      step();
    end
    check_eq("bp_accepts",  sent,      2);
    check_eq("bp_in_ready", in_ready,  1'b0);
    check_eq("bp_valid",    out_valid, 1'b1);
    out_ready = 1'b1;
    pops0 = n_pops;
    for (int c = 0; c < 30 && !(sent == 4 && scb.size() == 0); c++) begin
      in_valid = (sent < 4);
      in_a = va[(sent < 4) ? sent : 3];
      in_b = vb[(sent < 4) ? sent : 3];
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    check_eq("bp_pops", n_pops - pops0, 4);
    check_eq("bp_left", scb.size(), 0);

    // Reset while full drops both buffered beats.
    out_ready = 1'b0;
    in_config = CFG_E5M2;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      step();
    end
    in_valid = 1'b0;
    check_eq("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    held_v = 1'b0;
    scb.delete();
    check_eq("mid_rst_valid",    out_valid,   1'b0);
    check_eq("mid_rst_in_ready", in_ready,    1'b0);
    check_eq("mid_rst_diff",     out_diff,    20'h0);
    check_eq("mid_rst_man_big",  out_man_big, 24'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_ready_back", in_ready,  1'b1);
    check_eq("mid_rst_still_idle", out_valid, 1'b0);

    // Random stream with random stalls; some B operands are near or equal to A to force ties.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_a      = $urandom;
      case ($urandom_range(0, 3))
        0:       in_b = in_a;
        1:       in_b = in_a ^ 32'($urandom_range(0, 255));
        default: in_b = $urandom;
      endcase
      in_config = CFG_W'($urandom_range(0, 7));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && scb.size() != 0; c++) step();
    check_eq("drain_left",  scb.size(), 0);
    check_eq("drain_valid", out_valid,  1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
